// File: rtl/sqrt_fp.sv
// Multi-cycle unsigned fixed-point square root, restoring two-bits-per-step, one root bit per clock.
// Result pulses valid (WIDTH+FBITS)/2 cycles after an accepted start; start is ignored while busy.
module sqrt_fp #(
   parameter int WIDTH = 32,
   parameter int FBITS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] rad,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] root,
   output logic [WIDTH-1:0] rem
);

   localparam int ITER = (WIDTH + FBITS) / 2;
   localparam int IW   = $clog2(ITER + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CALC = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] q;
   logic [WIDTH+1:0] ac;
   logic [IW-1:0]    i;

   logic [WIDTH+1:0] t;
   logic [WIDTH+1:0] ac_next;
   logic [WIDTH-1:0] x_next;
   logic [WIDTH-1:0] q_next;
   logic             unused_t;

   // Trial subtraction: a non-negative result means the next root bit is 1.
   always_comb begin
      t        = ac - {q, 2'b01};
      unused_t = t[WIDTH];
      x_next   = {x[WIDTH-3:0], 2'b00};
      if (!t[WIDTH+1]) begin
         ac_next = {t[WIDTH-1:0], x[WIDTH-1:WIDTH-2]};
         q_next  = {q[WIDTH-2:0], 1'b1};
      end else begin
         ac_next = {ac[WIDTH-1:0], x[WIDTH-1:WIDTH-2]};
         q_next  = {q[WIDTH-2:0], 1'b0};
      end
   end

   assign busy = (state == CALC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         valid <= 1'b0;
         root  <= '0;
         rem   <= '0;
         x     <= '0;
         q     <= '0;
         ac    <= '0;
         i     <= '0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  {ac, x} <= {{(WIDTH+2){1'b0}}, rad} << 2;
                  q       <= '0;
                  i       <= '0;
                  state   <= CALC;
               end
            end
            default: begin
               ac <= ac_next;
               x  <= x_next;
               q  <= q_next;
               if (i == IW'(ITER - 1)) begin
                  root  <= q_next;
                  rem   <= ac_next[WIDTH+1:2];
                  valid <= 1'b1;
                  state <= IDLE;
               end else begin
                  i <= i + IW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_fp.sv
// Bench for sqrt_fp: directed and random radicands against an exact integer square-root model,
// plus cycle-accurate handshake, start-while-busy, start-in-valid-cycle and mid-run reset checks.
module tb_sqrt_fp;

   localparam int WIDTH = 32;
   localparam int FBITS = 10;
   localparam int ITER  = (WIDTH + FBITS) / 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] rad;
   logic             busy;
   logic             valid;
   logic [WIDTH-1:0] root;
   logic [WIDTH-1:0] rem;

   int checks;
   int errors;

   sqrt_fp #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .rad   (rad),
      .busy  (busy),
      .valid (valid),
      .root  (root),
      .rem   (rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Largest r with r*r <= rad*2^FBITS, found by binary search on exact 64-bit integers.
   function automatic void ref_sqrt(input logic [WIDTH-1:0] r, output longint rt, output longint rm);
      longint n, lo, hi, mid;
      n  = {32'b0, r};
      n  = n << FBITS;
      lo = 0;
      hi = longint'(1) << ((WIDTH + FBITS) / 2);
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= n) lo = mid;
         else                hi = mid;
      end
      rt = lo;
      rm = n - lo * lo;
   endfunction

   // Issue start with radicand r; returns just after the accepting edge.
   task automatic launch(input logic [WIDTH-1:0] r);
      start = 1'b1;
      rad   = r;
      @(posedge clk); #1;
      start = 1'b0;
      rad   = $urandom;
      check("busy_after_start", {busy, valid}, 2'b10);
   endtask

   // Walk the remaining cycles of a run, optionally pulsing start mid-run, then check the result.
   task automatic finish_run(input string tag, input logic [WIDTH-1:0] exp_root,
                             input logic [WIDTH-1:0] exp_rem, input bit mid, input logic [WIDTH-1:0] alt);
      for (int k = 1; k < ITER; k++) begin
         if (mid && k == 5) begin
            start = 1'b1;
            rad   = alt;
         end
         @(posedge clk); #1;
         start = 1'b0;
         check({tag, "_busy_hold"}, {busy, valid}, 2'b10);
      end
      @(posedge clk); #1;
      check({tag, "_done"}, {busy, valid}, 2'b01);
      check({tag, "_root"}, root, exp_root);
      check({tag, "_rem"}, rem, exp_rem);
   endtask

   task automatic valid_drops(input string tag, input logic [WIDTH-1:0] exp_root, input logic [WIDTH-1:0] exp_rem);
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, {busy, valid}, 2'b00);
      check({tag, "_root_hold"}, root, exp_root);
      check({tag, "_rem_hold"}, rem, exp_rem);
   endtask

   initial begin
      longint rt, rm;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] dir_rad  [8] = '{32'd0, 32'd1, 32'd121, 32'd81, 32'd4096, 32'd90, 32'd255, 32'hFFFF_FFFF};
      logic [WIDTH-1:0] dir_root [8] = '{32'd0, 32'd32, 32'd352, 32'd288, 32'd2048, 32'd303, 32'd510, 32'd2097151};
      logic [WIDTH-1:0] dir_rem  [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd351, 32'd1020, 32'd4193279};
      bit saw_valid;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b1;
      rad    = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags", {busy, valid}, 2'b00);
      check("reset_root", root, 0);
      check("reset_rem", rem, 0);
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed radicands with known exact and inexact roots.
      for (int d = 0; d < 8; d++) begin
         launch(dir_rad[d]);
         finish_run($sformatf("dir%0d", d), dir_root[d], dir_rem[d], 1'b0, '0);
         valid_drops($sformatf("dir%0d", d), dir_root[d], dir_rem[d]);
      end

      // Random radicands against the model; half with a mid-run start pulse that must be ignored.
      for (int n = 0; n < 10; n++) begin
         r = $urandom;
         if (n % 3 == 1) r = r >> $urandom_range(31, 8);
         ref_sqrt(r, rt, rm);
         launch(r);
         finish_run($sformatf("rnd%0d", n), rt[WIDTH-1:0], rm[WIDTH-1:0], n[0], $urandom);
         valid_drops($sformatf("rnd%0d", n), rt[WIDTH-1:0], rm[WIDTH-1:0]);
      end

      // Back-to-back: start asserted in the valid cycle begins a new run immediately.
      ref_sqrt(32'd50000, rt, rm);
      launch(32'd50000);
      finish_run("b2b_a", rt[WIDTH-1:0], rm[WIDTH-1:0], 1'b0, '0);
      ref_sqrt(32'd7, rt, rm);
      launch(32'd7);
      finish_run("b2b_b", rt[WIDTH-1:0], rm[WIDTH-1:0], 1'b0, '0);
      valid_drops("b2b_b", rt[WIDTH-1:0], rm[WIDTH-1:0]);

      // Reset at iteration 10 aborts the run: outputs cleared and no valid afterwards.
      launch(32'd999_999);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_flags", {busy, valid}, 2'b00);
      check("abort_root", root, 0);
      check("abort_rem", rem, 0);
      saw_valid = 1'b0;
      repeat (ITER + 4) begin
         @(posedge clk); #1;
         if (valid || busy) saw_valid = 1'b1;
      end
      check("abort_no_valid", saw_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
